branch_update_unit: RTL and testbench

- Write-side driver for the branch predictor cache.
- Accepts resolved branches from the execute stage and detects mispredictions.
- On a misprediction, issues a one-cycle flush/redirect to fetch.
- Buffers resolved branches in a small FIFO and replays each as a we pulse on the cache update port (update_pc, branch_taken, wb_addr).
- Samples the cache's evict/update_history response and keeps performance counters.

---
 rtl/branch_update_unit.sv | 218 +++++++++++++++++++++
 tb/tb_branch_update_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_unit.sv
// Branch update unit: resolves execute-stage branches, flushes fetch on
// mispredict, and replays buffered outcomes into the branch predictor cache.
module branch_update_unit #(
   parameter int ADDR_W     = 10,
   parameter int HIST_W     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ADDR_W-1:0] res_pc,
   input  logic              res_taken,
   input  logic [ADDR_W-1:0] res_target,
   input  logic              pred_taken,
   input  logic [ADDR_W-1:0] pred_target,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              we,
   output logic [ADDR_W-1:0] update_pc,
   output logic              branch_taken,
   output logic [ADDR_W-1:0] wb_addr,
   input  logic [HIST_W-1:0] update_history,
   input  logic              evict,
   output logic [HIST_W-1:0] last_history,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count,
   output logic [CNT_W-1:0]  evict_count,
   output logic              busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ADDR_W-1:0] r_pc_mem  [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_tgt_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_tk_mem;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;

   logic              r_flush;
   logic [ADDR_W-1:0] r_redirect;
   logic [ADDR_W-1:0] r_upd_pc;
   logic              r_upd_taken;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [HIST_W-1:0] r_last_hist;
   logic [CNT_W-1:0]  r_branch_cnt;
   logic [CNT_W-1:0]  r_mis_cnt;
   logic [CNT_W-1:0]  r_evict_cnt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_mispredict;
   logic [ADDR_W-1:0] w_res_next;
   logic [PTR_W-1:0]  w_rd_next;
   logic              w_load;
   logic [PTR_W-1:0]  w_load_ptr;
   logic [ADDR_W-1:0] w_load_pc;
   logic [ADDR_W-1:0] w_load_tgt;
   logic              w_load_tk;

   assign w_full    = (r_count == OCC_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push    = res_valid & ~w_full;
   assign w_pop     = (r_state == S_SETTLE);
   assign w_rd_next = r_rd_ptr + PTR_W'(1);

   assign w_mispredict = (pred_taken != res_taken) ||
                         (res_taken && (pred_target != res_target));

   assign w_res_next = res_taken ? res_target
                                 : res_pc + ADDR_W'(1);

   assign w_load_pc  = r_pc_mem[w_load_ptr];
   assign w_load_tgt = r_tgt_mem[w_load_ptr];
   assign w_load_tk  = r_tk_mem[w_load_ptr];

   assign res_ready        = ~w_full;
   assign flush            = r_flush;
   assign redirect_pc      = r_redirect;
   assign we               = (r_state == S_ISSUE);
   assign update_pc        = r_upd_pc;
   assign branch_taken     = r_upd_taken;
   assign wb_addr          = r_wb_addr;
   assign last_history     = r_last_hist;
   assign branch_count     = r_branch_cnt;
   assign mispredict_count = r_mis_cnt;
   assign evict_count      = r_evict_cnt;
   assign busy             = ~w_empty | (r_state != S_IDLE);

   // Entry storage; contents are don't-care once pointers are reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]  <= res_pc;
         r_tgt_mem[r_wr_ptr] <= res_target;
         r_tk_mem[r_wr_ptr]  <= res_taken;
      end
   end

   // FIFO pointers and occupancy; simultaneous push/pop keeps the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= w_rd_next;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Mispredict flush pulse and the corrected fetch address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush    <= 1'b0;
         r_redirect <= '0;
      end else begin
         r_flush <= w_push & w_mispredict;
         if (w_push && w_mispredict) r_redirect <= w_res_next;
      end
   end

   // Update FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and head-load selection; a pop leaves the next
   // head at rd_ptr+1 when more than one entry is buffered.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_ptr  = r_rd_ptr;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = S_ISSUE;
               w_load      = 1'b1;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_count > OCC_W'(1)) begin
               w_state_nxt = S_ISSUE;
               w_load      = 1'b1;
               w_load_ptr  = w_rd_next;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Cache update fields, held stable from load through the we cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_upd_pc    <= '0;
         r_upd_taken <= 1'b0;
         r_wb_addr   <= '0;
      end else if (w_load) begin
         r_upd_pc    <= w_load_pc;
         r_upd_taken <= w_load_tk;
         r_wb_addr   <= w_load_tk ? w_load_tgt
                                  : w_load_pc + ADDR_W'(1);
      end
   end

   // Cache response capture during SETTLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_hist <= '0;
         r_evict_cnt <= '0;
      end else if (w_pop) begin
         r_last_hist <= update_history;
         if (evict && (r_evict_cnt != '1))
            r_evict_cnt <= r_evict_cnt + CNT_W'(1);
      end
   end

   // Saturating accept and mispredict statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_branch_cnt <= '0;
         r_mis_cnt    <= '0;
      end else if (w_push) begin
         if (r_branch_cnt != '1)
            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
         if (w_mispredict && (r_mis_cnt != '1))
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_update_unit.sv
// Self-checking bench for branch_update_unit: directed cases followed by
// random traffic against a timeline-based reference model.
module tb_branch_update_unit;

   localparam int AW  = 10;
   localparam int HW  = 3;
   localparam int D   = 4;
   localparam int CW  = 6;
   localparam int SAT = (1 << CW) - 1;
   localparam int MAXE = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res_pc;
   logic          res_taken;
   logic [AW-1:0] res_target;
   logic          pred_taken;
   logic [AW-1:0] pred_target;
   logic          flush;
   logic [AW-1:0] redirect_pc;
   logic          we;
   logic [AW-1:0] update_pc;
   logic          branch_taken;
   logic [AW-1:0] wb_addr;
   logic [HW-1:0] update_history;
   logic          evict;
   logic [HW-1:0] last_history;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;
   logic [CW-1:0] evict_count;
   logic          busy;

   always #5 clk = ~clk;

   branch_update_unit #(
      .ADDR_W(AW), .HIST_W(HW), .FIFO_DEPTH(D), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_pc(res_pc), .res_taken(res_taken),
      .res_target(res_target), .pred_taken(pred_taken),
      .pred_target(pred_target), .flush(flush),
      .redirect_pc(redirect_pc), .we(we),
      .update_pc(update_pc), .branch_taken(branch_taken),
      .wb_addr(wb_addr), .update_history(update_history),
      .evict(evict), .last_history(last_history),
      .branch_count(branch_count),
      .mispredict_count(mispredict_count),
      .evict_count(evict_count), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: each accepted entry gets the cycle index at which
   // its cache write begins; a write slot lasts two cycles and the entry
   // leaves the buffer at the end of its second cycle.
   int t;
   int e_pc  [MAXE];
   int e_tk  [MAXE];
   int e_wb  [MAXE];
   int e_iss [MAXE];
   int n_acc, n_pop, n_we, last_iss;
   int m_br, m_mis, m_ev, m_hist, m_flush, m_redir;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_acc = 0; n_pop = 0; n_we = 0; last_iss = -100;
      m_br = 0; m_mis = 0; m_ev = 0; m_hist = 0;
      m_flush = 0; m_redir = 0;
   endtask

   task automatic step(input bit v, input logic [AW-1:0] pc,
                       input bit tk, input logic [AW-1:0] tgt,
                       input bit ptk, input logic [AW-1:0] ptgt,
                       input bit ev, input logic [HW-1:0] hist);
      bit acc;
      bit mis;
      logic [AW-1:0] nxt;
      int occ;
      int iss;
      res_valid = v; res_pc = pc; res_taken = tk;
      res_target = tgt; pred_taken = ptk; pred_target = ptgt;
      evict = ev; update_history = hist;
      occ = n_acc - n_pop;
      chk("res_ready", res_ready, occ < D);
      acc = v && (occ < D);
      @(posedge clk);
      t++;
      if (n_pop < n_acc && e_iss[n_pop] + 2 == t) begin
         m_hist = hist;
         if (ev && m_ev < SAT) m_ev++;
         n_pop++;
      end
      m_flush = 0;
      if (acc && n_acc < MAXE) begin
         mis = (ptk != tk) || (tk && ptgt != tgt);
         nxt = tk ? tgt : pc + 1'b1;
         iss = (t + 1 > last_iss + 2) ? t + 1 : last_iss + 2;
         e_pc[n_acc] = pc; e_tk[n_acc] = tk;
         e_wb[n_acc] = nxt; e_iss[n_acc] = iss;
         last_iss = iss;
         n_acc++;
         if (m_br < SAT) m_br++;
         if (mis) begin
            if (m_mis < SAT) m_mis++;
            m_flush = 1;
            m_redir = nxt;
         end
      end
      #1;
      chk("flush", flush, m_flush);
      chk("redirect_pc", redirect_pc, m_redir);
      if (n_we < n_acc && e_iss[n_we] == t) begin
         chk("we", we, 1);
         chk("update_pc", update_pc, e_pc[n_we]);
         chk("branch_taken", branch_taken, e_tk[n_we]);
         chk("wb_addr", wb_addr, e_wb[n_we]);
         n_we++;
      end else begin
         chk("we", we, 0);
      end
      chk("busy", busy, (n_acc - n_pop) != 0);
      chk("last_history", last_history, m_hist);
      chk("branch_count", branch_count, m_br);
      chk("mispredict_count", mispredict_count, m_mis);
      chk("evict_count", evict_count, m_ev);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, 0, '0);
   endtask

   task automatic check_reset_state();
      chk("rst_we", we, 0);
      chk("rst_flush", flush, 0);
      chk("rst_busy", busy, 0);
      chk("rst_branch_count", branch_count, 0);
      chk("rst_mispredict_count", mispredict_count, 0);
      chk("rst_evict_count", evict_count, 0);
      chk("rst_last_history", last_history, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
   endtask

   initial begin
      rst = 1'b1;
      res_valid = 0; res_pc = '0; res_taken = 0; res_target = '0;
      pred_taken = 0; pred_target = '0; evict = 0; update_history = '0;
      t = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      rst = 1'b0;
      #1;
      chk("ready_after_reset", res_ready, 1);

      // Correct prediction, single write reaching ISSUE one edge later
      step(1, 10'h00F, 1, 10'h00A, 1, 10'h00A, 0, '0);
      chk("dir_ok_noflush", flush, 0);
      chk("dir_ok_we_early", we, 0);
      idle(1);
      chk("dir_ok_we", we, 1);
      chk("dir_ok_pc", update_pc, 10'h00F);
      chk("dir_ok_tk", branch_taken, 1);
      chk("dir_ok_wb", wb_addr, 10'h00A);
      chk("dir_ok_bc", branch_count, 1);
      idle(3);

      // Not-taken mispredict at top of address space wraps
      step(1, 10'h3FF, 0, 10'h123, 1, 10'h123, 0, '0);
      chk("dir_nt_flush", flush, 1);
      chk("dir_nt_redir", redirect_pc, 10'h000);
      idle(1);
      chk("dir_nt_flush_off", flush, 0);
      chk("dir_nt_wb", wb_addr, 10'h000);
      chk("dir_nt_mc", mispredict_count, 1);
      idle(3);

      // Target mispredict
      step(1, 10'h050, 1, 10'h020, 1, 10'h021, 0, '0);
      chk("dir_tg_flush", flush, 1);
      chk("dir_tg_redir", redirect_pc, 10'h020);
      idle(4);

      // Evict and history captured during SETTLE
      step(1, 10'h100, 0, '0, 0, '0, 0, '0);
      idle(2);
      step(0, '0, 0, '0, 0, '0, 1, 3'b101);
      chk("dir_ev_cnt", evict_count, 1);
      chk("dir_ev_hist", last_history, 3'b101);
      idle(3);

      // Back-to-back pushes, then a longer burst that fills the FIFO
      for (int i = 0; i < 5; i++)
         step(1, AW'(10'h200 + i), 1, AW'(10'h040 + i),
              1, AW'(10'h040 + i), 0, '0);
      idle(14);
      for (int i = 0; i < 12; i++)
         step(1, AW'(10'h300 + i), i[0], AW'(10'h080 + i),
              i[1], AW'(10'h080 + i), 0, '0);
      idle(30);

      // Random traffic with a reset asserted mid-operation
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, AW'($urandom),
              1'($urandom), AW'($urandom_range(0, 7)),
              1'($urandom), AW'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, HW'($urandom));
         if (i == 150) begin
            #2;
            rst = 1'b1;
            #1;
            check_reset_state();
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_reset();
            #1;
            chk("ready_after_midreset", res_ready, 1);
         end
      end
      idle(20);
      chk("sat_branch_count", branch_count, SAT);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
